// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use, redirect, memory-busy
// stalls and the context-switch drain/ack handshake.
module pipe_hazard_ctrl #(
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             i_mem_busy,
  input  logic             d_mem_busy,
  input  logic             ctx_req,
  input  logic             stat_clr,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             ctx_ack,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    CTX_HOLD = 2'd2
  } state_e;

  localparam int DW = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_L = DW'(PIPE_DEPTH);

  state_e           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             ctx_ack_q, ctx_ack_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic lu, lu_act;
  logic pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c, pipe_freeze_c;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) ||
               (id_rs2_used && (id_rs2 == ex_rd)));

  // A load-use stall only counts when neither freeze nor redirect outranks it.
  assign lu_act = lu && !d_mem_busy && !ex_redirect;

  always_comb begin
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    pipe_freeze_c = 1'b0;
    case (state_q)
      RUN, DRAIN: begin
        if (state_q == DRAIN) begin
          pc_hold_c    = 1'b1;
          ifid_flush_c = 1'b1;
        end
        if (d_mem_busy) begin
          pipe_freeze_c = 1'b1;
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          ifid_flush_c  = 1'b0;
        end else if (ex_redirect) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          pc_hold_c     = 1'b0;
        end else if (lu) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
          ifid_flush_c  = 1'b0;
        end else if (i_mem_busy) begin
          pc_hold_c    = 1'b1;
          ifid_flush_c = 1'b1;
        end
      end
      CTX_HOLD: begin
        pc_hold_c    = 1'b1;
        ifid_flush_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (ctx_req) begin
          state_d = DRAIN;
          cnt_d   = DEPTH_L;
        end
      end
      DRAIN: begin
        if (!d_mem_busy && !lu_act && (cnt_q != '0)) cnt_d = cnt_q - DW'(1);
        if (!ctx_req) state_d = RUN;
        else if (cnt_d == '0) state_d = CTX_HOLD;
      end
      CTX_HOLD: begin
        if (!ctx_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctx_ack_d = (state_d == CTX_HOLD);
    stall_d   = stall_q;
    if (stat_clr) stall_d = '0;
    else if ((state_q == RUN) && pc_hold_c && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ctx_ack_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctx_ack_q <= ctx_ack_d;
      stall_q   <= stall_d;
    end
  end

  // Reset forces every combinational control low, independent of inputs.
  assign pc_hold      = reset & pc_hold_c;
  assign ifid_hold    = reset & ifid_hold_c;
  assign ifid_flush   = reset & ifid_flush_c;
  assign idex_bubble  = reset & idex_bubble_c;
  assign pipe_freeze  = reset & pipe_freeze_c;
  assign ctx_ack      = ctx_ack_q;
  assign stall_cycles = stall_q;
  assign dbg_state    = state_q;

endmodule
